// File: rtl/usb_phy_pkg.sv
// rtl/usb_phy_pkg.sv - shared FSM state type and default widths for the NRZI receive path
package usb_phy_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_ERR  = 2'd2
   } deser_state_t;

   localparam int DEF_STUFF_LEN = 6;
   localparam int DEF_BYTE_W    = 8;

endpackage

// File: rtl/usb_unstuff_counter.sv
// rtl/usb_unstuff_counter.sv - consecutive-ones counter flagging stuffed-bit drops and stuff violations
module usb_unstuff_counter #(
   parameter int STUFF_LEN = usb_phy_pkg::DEF_STUFF_LEN
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_restart,
   input  logic i_clear,
   input  logic i_en,
   input  logic i_bit,
   output logic o_drop,
   output logic o_viol
);

   localparam int OW = $clog2(STUFF_LEN + 1);
   localparam logic [OW-1:0] LIM = OW'(STUFF_LEN);

   logic [OW-1:0] ones;
   logic [OW-1:0] ones_eff;
   logic          at_limit;

   // A restarting packet is evaluated against a zero count in the same cycle.
   always_comb begin
      ones_eff = i_restart ? '0 : ones;
      at_limit = (ones_eff == LIM);
      o_drop   = i_en && at_limit && !i_bit;
      o_viol   = i_en && at_limit && i_bit;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         ones <= '0;
      end else if (i_en) begin
         ones <= (at_limit || !i_bit) ? '0 : ones_eff + OW'(1);
      end else begin
         ones <= ones_eff;
      end
   end

endmodule

// File: rtl/nrzi_unstuff_deser.sv
// rtl/nrzi_unstuff_deser.sv - NRZI decoder, bit unstuffer and LSB-first word deserialiser
module nrzi_unstuff_deser #(
   parameter int   STUFF_LEN  = usb_phy_pkg::DEF_STUFF_LEN,
   parameter int   BYTE_W     = usb_phy_pkg::DEF_BYTE_W,
   parameter logic INIT_LEVEL = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_data,
   input  logic              i_valid,
   input  logic              i_pkt_start,
   input  logic              i_eop,
   output logic              o_bit,
   output logic              o_bit_valid,
   output logic [BYTE_W-1:0] o_byte,
   output logic              o_byte_valid,
   output logic              o_stuff_err,
   output logic              o_pkt_end,
   output logic              o_partial
);

   import usb_phy_pkg::*;

   localparam int CW = $clog2(BYTE_W);
   localparam logic [CW-1:0] LAST = CW'(BYTE_W - 1);

   deser_state_t      state;
   deser_state_t      proc_state;
   logic              prev_level;
   logic              dec_bit;
   logic              pkt_done;
   logic              restart;
   logic              en;
   logic              drop;
   logic              viol;
   logic              keep;
   logic              word_full;
   logic [CW-1:0]     bcnt;
   logic [CW-1:0]     bcnt_eff;
   logic [CW-1:0]     bcnt_new;
   logic [BYTE_W-1:0] shift;
   logic [BYTE_W-1:0] shift_eff;
   logic [BYTE_W-1:0] shift_new;

   // With i_eop present the cycle's bit belongs to the ending packet; a lone
   // i_pkt_start makes the bit the first of a fresh packet.
   always_comb begin
      pkt_done   = i_eop && (state != ST_IDLE);
      restart    = i_pkt_start && !pkt_done;
      proc_state = restart ? ST_RUN : state;
      dec_bit    = (i_data == prev_level);
      en         = i_valid && (proc_state == ST_RUN);
      keep       = en && !drop && !viol;
      bcnt_eff   = restart ? '0 : bcnt;
      shift_eff  = restart ? '0 : shift;
      word_full  = keep && (bcnt_eff == LAST);
      shift_new  = keep ? {dec_bit, shift_eff[BYTE_W-1:1]} : shift_eff;
      if (!keep)
         bcnt_new = bcnt_eff;
      else if (word_full)
         bcnt_new = '0;
      else
         bcnt_new = bcnt_eff + CW'(1);
   end

   usb_unstuff_counter #(
      .STUFF_LEN (STUFF_LEN)
   ) u_ones (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_restart (restart),
      .i_clear   (pkt_done),
      .i_en      (en),
      .i_bit     (dec_bit),
      .o_drop    (drop),
      .o_viol    (viol)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= ST_IDLE;
         prev_level   <= INIT_LEVEL;
         bcnt         <= '0;
         shift        <= '0;
         o_bit        <= 1'b0;
         o_bit_valid  <= 1'b0;
         o_byte       <= '0;
         o_byte_valid <= 1'b0;
         o_stuff_err  <= 1'b0;
         o_pkt_end    <= 1'b0;
         o_partial    <= 1'b0;
      end else begin
         if (i_valid)
            prev_level <= i_data;
         o_bit_valid <= keep;
         if (keep)
            o_bit <= dec_bit;
         o_byte_valid <= word_full;
         if (word_full)
            o_byte <= shift_new;
         o_stuff_err <= viol;
         o_pkt_end   <= pkt_done;
         o_partial   <= pkt_done && (bcnt_new != '0);
         if (pkt_done) begin
            bcnt  <= '0;
            shift <= '0;
         end else begin
            bcnt  <= bcnt_new;
            shift <= shift_new;
         end
         if (i_pkt_start)
            state <= ST_RUN;
         else if (pkt_done)
            state <= ST_IDLE;
         else if (viol)
            state <= ST_ERR;
      end
   end

endmodule
